// File: rtl/debug_capture.sv
// Change-compressed logic capture of the debug bus: arm, masked trigger, then
// {value, delta_time} entries pushed into a FIFO on every bus change.
module debug_capture #(
  parameter int DEBUG_BUS_SIZE = 4,
  parameter int DEPTH          = 16,
  parameter int TS_WIDTH       = 12
) (
  input  logic                               PCLK,
  input  logic                               PRESETN,
  input  logic [DEBUG_BUS_SIZE-1:0]          debug_in,
  input  logic                               arm,
  input  logic                               abort,
  input  logic [DEBUG_BUS_SIZE-1:0]          trig_mask,
  input  logic [DEBUG_BUS_SIZE-1:0]          trig_value,
  input  logic                               rd_en,
  output logic [DEBUG_BUS_SIZE+TS_WIDTH-1:0] rd_data,
  output logic                               rd_valid,
  output logic [$clog2(DEPTH):0]             level,
  output logic [1:0]                         state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int W  = DEBUG_BUS_SIZE + TS_WIDTH;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [DEBUG_BUS_SIZE-1:0] s_q, sp_q;
  logic [TS_WIDTH-1:0]       ts_q, ts_d, wr_ts;
  logic [AW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]             level_q, level_d;
  logic [W-1:0]              rd_data_q, rd_data_d;
  logic                      rd_valid_q;
  logic [W-1:0]              mem_q [DEPTH];

  logic full, empty, rd_do, want_wr, wr_do, clear, trig, changed, ts_max;
  logic [W-1:0] wr_data;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign rd_do   = rd_en && !empty;
  assign trig    = ((s_q ^ trig_value) & trig_mask) == '0;
  assign changed = (s_q != sp_q);
  assign ts_max  = (ts_q == '1);
  assign wr_data = {s_q, wr_ts};
  // A required write into a full FIFO only proceeds when a pop frees the slot.
  assign wr_do   = want_wr && (!full || rd_do);

  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    want_wr = 1'b0;
    wr_ts   = '0;
    clear   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (arm) begin
      state_d = ST_ARMED;
      clear   = 1'b1;
      ts_d    = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (trig) begin
            want_wr = 1'b1;
            ts_d    = TS_WIDTH'(1);
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (changed || ts_max) begin
            want_wr = 1'b1;
            wr_ts   = ts_q;
            ts_d    = TS_WIDTH'(1);
          end else begin
            ts_d = ts_q + TS_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end

    level_d = level_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (clear) begin
      level_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (wr_do) wptr_d = wptr_q + AW'(1);
      if (rd_do) rptr_d = rptr_q + AW'(1);
      if (wr_do && !rd_do) level_d = level_q + LW'(1);
      else if (rd_do && !wr_do) level_d = level_q - LW'(1);
    end
    if (wr_do && level_d == LW'(DEPTH)) state_d = ST_DONE;

    rd_data_d = rd_data_q;
    if (rd_do) rd_data_d = mem_q[rptr_q];
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      sp_q       <= '0;
      ts_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= debug_in;
      sp_q       <= s_q;
      ts_q       <= ts_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_do;
    end
  end

  always_ff @(posedge PCLK) begin
    if (wr_do) mem_q[wptr_q] <= wr_data;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign level    = level_q;
  assign state    = state_q;

endmodule

// File: tb/tb_debug_capture.sv
// Randomized self-checking bench for debug_capture against a queue-based model.
module tb_debug_capture;

  logic        PCLK = 1'b0;
  logic        PRESETN;
  logic [3:0]  debug_in, trig_mask, trig_value;
  logic        arm, abort, rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [4:0]  level;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  debug_capture #(.DEBUG_BUS_SIZE(4), .DEPTH(16), .TS_WIDTH(12)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .debug_in(debug_in), .arm(arm), .abort(abort),
    .trig_mask(trig_mask), .trig_value(trig_value), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .level(level), .state(state)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: entries are {bus value, cycles since the previous entry}.
  logic [15:0] q[$];
  int          m_state, cyc, m_last;
  logic [3:0]  m_s, m_sp;
  logic [15:0] m_rd_data;
  logic        m_rd_valid;

  function automatic void model_reset();
    q.delete();
    m_state = 0; cyc = 0; m_last = 0;
    m_s = '0; m_sp = '0; m_rd_data = '0; m_rd_valid = 1'b0;
  endfunction

  function automatic void model_eval();
    bit rd;
    bit wr = 0;
    logic [15:0] e = '0;
    logic [15:0] popped = '0;
    int delta;
    int nst = m_state;
    rd = rd_en && (q.size() > 0);
    if (rd) popped = q[0];
    if (abort) nst = 0;
    else if (arm) nst = 1;
    else if (m_state == 1) begin
      if (((m_s ^ trig_value) & trig_mask) == 4'h0) begin
        wr = 1; e = {m_s, 12'd0}; m_last = cyc; nst = 2;
      end
    end else if (m_state == 2) begin
      delta = cyc - m_last;
      if (m_s != m_sp || delta == 4095) begin
        wr = 1; e = {m_s, 12'(delta)}; m_last = cyc;
      end
    end
    if (rd) void'(q.pop_front());
    if (!abort && arm) q.delete();
    if (wr && q.size() < 16) begin
      q.push_back(e);
      if (q.size() == 16) nst = 3;
    end
    m_rd_valid = rd;
    if (rd) m_rd_data = popped;
    m_sp = m_s; m_s = debug_in; cyc++; m_state = nst;
  endfunction

  task automatic step();
    model_eval();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESETN = 1'b0; debug_in = '0; arm = 0; abort = 0; rd_en = 0;
    trig_mask = '0; trig_value = '0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    vectors++;
    if ({state, level, rd_valid, rd_data} !== {2'd0, 5'd0, 1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL reset: state=%0d level=%0d rd_valid=%b rd_data=%h required 0/0/0/0",
               state, level, rd_valid, rd_data);
    end
    PRESETN = 1'b1;
  endtask

  task automatic test_trigger();
    logic [3:0] seq [4] = '{4'h3, 4'hA, 4'hA, 4'h5};
    logic [15:0] exp [2] = '{16'hA000, 16'h5002};
    trig_mask = 4'hF; trig_value = 4'hA;
    debug_in = seq[0]; arm = 1; step(); arm = 0;
    for (int i = 1; i < 4; i++) begin debug_in = seq[i]; step(); end
    step();
    vectors++;
    if (state !== 2'd2 || level !== 5'd2 || m_state != 2 || q.size() != 2) begin
      miscompares++;
      $display("FAIL trig_state: state=%0d level=%0d required 2/2 (model %0d/%0d)",
               state, level, m_state, q.size());
    end
    for (int i = 0; i < 2; i++) begin
      rd_en = 1; step(); rd_en = 0;
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== exp[i] || m_rd_data !== exp[i]) begin
        miscompares++;
        $display("FAIL trig_entry%0d: rd_valid=%b rd_data=%h required 1/%h", i, rd_valid, rd_data, exp[i]);
      end
    end
  endtask

  task automatic test_keepalive();
    logic [3:0] v = 4'($urandom);
    logic [15:0] e;
    abort = 1; step(); abort = 0;
    trig_mask = '0; debug_in = v; arm = 1; step(); arm = 0;
    repeat (5000) step();
    debug_in = ~v; step(); step();
    vectors++;
    if (level !== 5'(q.size()) || q.size() != 3) begin
      miscompares++;
      $display("FAIL keepalive_level: level=%0d required %0d (3)", level, q.size());
    end
    for (int i = 0; i < 16 && q.size() > 0; i++) begin
      e = q[0];
      rd_en = 1; step(); rd_en = 0;
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        miscompares++;
        $display("FAIL keepalive_entry%0d: rd_valid=%b rd_data=%h required 1/%h", i, rd_valid, rd_data, e);
      end
      if (i == 1) begin
        vectors++;
        if (rd_data !== {v, 12'hFFF}) begin
          miscompares++;
          $display("FAIL keepalive_delta: rd_data=%h required %h", rd_data, {v, 12'hFFF});
        end
      end
    end
  endtask

  task automatic test_fill();
    abort = 1; step(); abort = 0;
    trig_mask = '0; debug_in = 4'($urandom); arm = 1; step(); arm = 0;
    for (int i = 0; i < 45; i++) begin debug_in = debug_in ^ (4'($urandom_range(1, 15))); step(); end
    vectors++;
    if (state !== 2'd3 || level !== 5'd16 || m_state != 3 || q.size() != 16) begin
      miscompares++;
      $display("FAIL fill_done: state=%0d level=%0d required 3/16", state, level);
    end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1; step(); rd_en = 0;
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== m_rd_data) begin
        miscompares++;
        $display("FAIL fill_entry%0d: rd_valid=%b rd_data=%h required 1/%h", i, rd_valid, rd_data, m_rd_data);
      end
    end
  endtask

  task automatic test_full_read();
    logic [15:0] oldest;
    logic [3:0] v = 4'($urandom);
    trig_mask = '0; debug_in = v; arm = 1; step(); arm = 0;
    for (int i = 0; i < 40 && q.size() < 15; i++) begin debug_in = ~debug_in; step(); end
    oldest = q[0];
    debug_in = ~debug_in; rd_en = 1; step(); rd_en = 0;
    vectors++;
    if (level !== 5'd15 || state !== 2'd2 || rd_valid !== 1'b1 || rd_data !== oldest ||
        oldest !== {v, 12'h000}) begin
      miscompares++;
      $display("FAIL full_read: level=%0d state=%0d rd_valid=%b rd_data=%h required 15/2/1/%h",
               level, state, rd_valid, rd_data, {v, 12'h000});
    end
    debug_in = ~debug_in; step();
    vectors++;
    if (level !== 5'd16 || state !== 2'd3) begin
      miscompares++;
      $display("FAIL full_read_done: level=%0d state=%0d required 16/3", level, state);
    end
  endtask

  task automatic test_empty_abort();
    logic [4:0] kept;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin rd_en = 1; step(); end
    rd_en = 1; step(); rd_en = 0;
    vectors++;
    if (rd_valid !== 1'b0 || level !== 5'd0 || rd_data !== m_rd_data) begin
      miscompares++;
      $display("FAIL empty_read: rd_valid=%b level=%0d rd_data=%h required 0/0/%h",
               rd_valid, level, rd_data, m_rd_data);
    end
    trig_mask = '0; arm = 1; step(); arm = 0;
    for (int i = 0; i < 6; i++) begin debug_in = ~debug_in; step(); end
    abort = 1; step(); abort = 0;
    kept = 5'(q.size());
    vectors++;
    if (state !== 2'd0 || level !== kept || kept == 5'd0) begin
      miscompares++;
      $display("FAIL abort: state=%0d level=%0d required 0/%0d", state, level, kept);
    end
    abort = 1; arm = 1; step(); abort = 0; arm = 0;
    vectors++;
    if (state !== 2'd0 || level !== kept) begin
      miscompares++;
      $display("FAIL abort_vs_arm: state=%0d level=%0d required 0/%0d", state, level, kept);
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      rd_en = 1; step(); rd_en = 0;
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== m_rd_data) begin
        miscompares++;
        $display("FAIL abort_drain%0d: rd_valid=%b rd_data=%h required 1/%h", i, rd_valid, rd_data, m_rd_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    trig_mask = '0; arm = 1; step(); arm = 0;
    for (int i = 0; i < 5; i++) begin debug_in = ~debug_in; step(); end
    PRESETN = 1'b0;
    #2;
    vectors++;
    if ({state, level, rd_valid, rd_data} !== {2'd0, 5'd0, 1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_mid: state=%0d level=%0d rd_valid=%b rd_data=%h required 0/0/0/0",
               state, level, rd_valid, rd_data);
    end
    model_reset();
    @(posedge PCLK); #1;
    PRESETN = 1'b1;
    trig_mask = 4'hF; trig_value = 4'h6; debug_in = 4'h6; arm = 1; step(); arm = 0;
    step(); debug_in = 4'h9; step(); step();
    vectors++;
    if (state !== 2'd2 || level !== 5'd2 || q.size() != 2) begin
      miscompares++;
      $display("FAIL reset_rearm: state=%0d level=%0d required 2/2", state, level);
    end
    for (int i = 0; i < 2; i++) begin
      rd_en = 1; step(); rd_en = 0;
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== m_rd_data) begin
        miscompares++;
        $display("FAIL reset_rearm_entry%0d: rd_data=%h required %h", i, rd_data, m_rd_data);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      trig_mask = 4'($urandom); trig_value = 4'($urandom);
      arm = 1; step(); arm = 0;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 2) == 0) debug_in = 4'($urandom);
        rd_en = ($urandom_range(0, 3) == 0);
        abort = ($urandom_range(0, 199) == 0);
        arm   = ($urandom_range(0, 149) == 0);
        step();
        vectors++;
        if (state !== 2'(m_state) || level !== 5'(q.size()) || rd_valid !== m_rd_valid) begin
          miscompares++;
          $display("FAIL rand_ctrl r%0d c%0d: state=%0d level=%0d rd_valid=%b required %0d/%0d/%b",
                   r, i, state, level, rd_valid, m_state, q.size(), m_rd_valid);
        end
        if (m_rd_valid) begin
          vectors++;
          if (rd_data !== m_rd_data) begin
            miscompares++;
            $display("FAIL rand_data r%0d c%0d: rd_data=%h required %h", r, i, rd_data, m_rd_data);
          end
        end
      end
      arm = 0; abort = 0; rd_en = 0;
    end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_keepalive();
    test_fill();
    test_full_read();
    test_empty_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
